// File: rtl/ecc_195_err_stat_pkg.sv
// Shared encodings for the ECC error-statistics stage: word error class,
// capture FSM state and the priority classifier.
package ecc_195_err_stat_pkg;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_SBIT  = 2'd1,
    ERR_DBIT  = 2'd2,
    ERR_FAULT = 2'd3
  } err_e;

  typedef enum logic {
    CAP_ARMED  = 1'b0,
    CAP_LOCKED = 1'b1
  } cap_e;

  // Fault outranks dbit outranks sbit; sbit+dbit together reads as dbit.
  function automatic err_e classify(input logic sbit, input logic dbit, input logic fault);
    if (fault) return ERR_FAULT;
    if (dbit)  return ERR_DBIT;
    if (sbit)  return ERR_SBIT;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/ecc_195_err_stat_if.sv
// Checked-word stream in (from the fault detector) and registered word stream out.
interface ecc_195_err_stat_if #(
  parameter int DATA_WIDTH = 195,
  parameter int ADDR_WIDTH = 8
);
  import ecc_195_err_stat_pkg::*;

  logic                  in_vld;
  logic                  in_rdy;
  logic [DATA_WIDTH-1:0] in_data;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic                  in_sbit;
  logic                  in_dbit;
  logic                  in_fault;
  logic                  out_vld;
  logic                  out_rdy;
  logic [DATA_WIDTH-1:0] out_data;
  err_e                  out_err;

  modport slave (
    input  in_vld, in_data, in_addr, in_sbit, in_dbit, in_fault, out_rdy,
    output in_rdy, out_vld, out_data, out_err
  );

  modport master (
    output in_vld, in_data, in_addr, in_sbit, in_dbit, in_fault, out_rdy,
    input  in_rdy, out_vld, out_data, out_err
  );

endinterface

// File: rtl/ecc_195_err_stat_sat_cnt.sv
// Saturating up-counter; a clear coincident with an increment restarts at one.
module ecc_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)
      q <= '0;
    else if (clr)
      q <= inc ? W'(1) : '0;
    else if (inc && (q != '1))
      q <= q + W'(1);
  end

endmodule

// File: rtl/ecc_195_err_stat.sv
// ECC error-statistics stage: one-entry registered slice for the checked word,
// per-class saturating counters, first-error capture and a sticky interrupt.
module ecc_195_err_stat
  import ecc_195_err_stat_pkg::*;
#(
  parameter int DATA_WIDTH  = 195,
  parameter int ADDR_WIDTH  = 8,
  parameter int CNT_WIDTH   = 16,
  parameter int SBIT_THRESH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  ecc_195_err_stat_if.slave     bus,
  input  logic                  clr,
  output logic [CNT_WIDTH-1:0]  sbit_cnt,
  output logic [CNT_WIDTH-1:0]  dbit_cnt,
  output logic [CNT_WIDTH-1:0]  fault_cnt,
  output logic [ADDR_WIDTH-1:0] first_addr,
  output err_e                  first_type,
  output logic                  err_irq
);

  localparam logic [CNT_WIDTH:0] THRESH = (CNT_WIDTH+1)'(SBIT_THRESH);

  logic acc;
  err_e cls;
  logic log_evt;
  logic sbit_inc, dbit_inc, fault_inc;
  logic [CNT_WIDTH-1:0] sbit_base;
  logic sbit_hit;
  cap_e st, st_nxt;
  logic cap_ld;

  assign bus.in_rdy = ~bus.out_vld | bus.out_rdy;
  assign acc        = bus.in_vld & bus.in_rdy;
  assign cls        = classify(bus.in_sbit, bus.in_dbit, bus.in_fault);
  assign log_evt    = acc & (cls != ERR_NONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_vld  <= 1'b0;
      bus.out_data <= '0;
      bus.out_err  <= ERR_NONE;
    end else if (acc) begin
      bus.out_vld  <= 1'b1;
      bus.out_data <= bus.in_data;
      bus.out_err  <= cls;
    end else if (bus.out_rdy) begin
      bus.out_vld  <= 1'b0;
    end
  end

  assign sbit_inc  = log_evt & (cls == ERR_SBIT);
  assign dbit_inc  = log_evt & (cls == ERR_DBIT);
  assign fault_inc = log_evt & (cls == ERR_FAULT);

  ecc_sat_cnt #(.W(CNT_WIDTH)) u_sbit_cnt (
    .clk(clk), .rst(rst), .clr(clr), .inc(sbit_inc), .q(sbit_cnt)
  );
  ecc_sat_cnt #(.W(CNT_WIDTH)) u_dbit_cnt (
    .clk(clk), .rst(rst), .clr(clr), .inc(dbit_inc), .q(dbit_cnt)
  );
  ecc_sat_cnt #(.W(CNT_WIDTH)) u_fault_cnt (
    .clk(clk), .rst(rst), .clr(clr), .inc(fault_inc), .q(fault_cnt)
  );

  // Threshold is judged on the post-clear count so a clr+sbit word counts as one.
  assign sbit_base = clr ? '0 : sbit_cnt;
  assign sbit_hit  = sbit_inc && (sbit_base != '1) &&
                     (({1'b0, sbit_base} + (CNT_WIDTH+1)'(1)) == THRESH);

  always_comb begin
    st_nxt = clr ? CAP_ARMED : st;
    cap_ld = 1'b0;
    if (log_evt && (st_nxt == CAP_ARMED)) begin
      cap_ld = 1'b1;
      st_nxt = CAP_LOCKED;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= CAP_ARMED;
      first_addr <= '0;
      first_type <= ERR_NONE;
    end else begin
      st <= st_nxt;
      if (cap_ld) begin
        first_addr <= bus.in_addr;
        first_type <= cls;
      end else if (clr) begin
        first_addr <= '0;
        first_type <= ERR_NONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      err_irq <= 1'b0;
    else
      err_irq <= (err_irq & ~clr) | sbit_hit |
                 (log_evt & ((cls == ERR_DBIT) | (cls == ERR_FAULT)));
  end

endmodule

// File: doc/ecc_195_err_stat.md
ECC_195_ERR_STAT -- requirements
Module: ecc_195_err_stat

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, 195, checked read-data width; ADDR_WIDTH, 8, FIFO read-address width; CNT_WIDTH, 16, error-counter width; SBIT_THRESH, 16, correctable-error count that raises the interrupt.
REQ-002 SHALL have ports (one clock; reset synchronous, active-high):
- clk  in  1  sole clock
- rst  in  1  synchronous active-high reset
- in_vld  in  1  checker outputs and address valid this cycle
- in_rdy  out  1  stage accepts input
- in_data  in  DATA_WIDTH  corrected or passthrough data from fault detector
- in_addr  in  ADDR_WIDTH  FIFO address of the word
- in_sbit  in  1  single-bit error corrected
- in_dbit  in  1  double-bit error detected
- in_fault  in  1  checker self-compare mismatch
- out_vld  out  1  registered word valid
- out_rdy  in  1  consumer accepts word
- out_data  out  DATA_WIDTH  registered data
- out_err  out  2  per-word class: 0 none, 1 sbit, 2 dbit, 3 fault
- sbit_cnt / dbit_cnt / fault_cnt  out  CNT_WIDTH each  saturating event counters
- first_addr  out  ADDR_WIDTH  address of first logged error
- first_type  out  2  class of first logged error
- err_irq  out  1  sticky interrupt
- clr  in  1  one-cycle pulse clearing counters, capture and interrupt

Function
REQ-003 SHALL accept a word when in_vld & in_rdy; in_rdy = ~out_vld | out_rdy (single-entry register, full throughput, no bubble).
REQ-004 SHALL present an accepted word on out_vld/out_data/out_err the next cycle (latency 1), holding all three stable while out_vld & ~out_rdy.
REQ-005 SHALL classify by priority fault > dbit > sbit; in_sbit & in_dbit together is class 2.
REQ-006 SHALL increment exactly one counter per accepted word of nonzero class, saturating at all-ones with no wrap.
REQ-007 SHALL ignore in_sbit/in_dbit/in_fault when no handshake occurs.
REQ-008 SHALL implement a capture FSM: ARMED (reset state) -> LOCKED on first accepted nonzero-class word, loading first_addr/first_type; LOCKED holds until clr; clr returns to ARMED.
REQ-009 SHALL set err_irq the cycle after any accepted class 2 or 3 word, or when sbit_cnt reaches SBIT_THRESH; err_irq stays set until clr.
REQ-010 SHALL, on clr coincident with an accepted error word, apply clr first then log the word: the matching counter becomes 1, FSM goes LOCKED capturing that word, err_irq follows REQ-009 on post-clear values.
REQ-011 SHALL leave the data path (REQ-003/004) unaffected by clr.
REQ-012 SHALL, with sbit_cnt saturated, keep err_irq set and counters unchanged on further sbit events.

Reset
REQ-013 SHALL on rst drive out_vld=0, out_data=0, out_err=0, all counters=0, first_addr=0, first_type=0, err_irq=0, FSM=ARMED.
REQ-014 SHALL discard any held word when rst asserts mid-backpressure; in_rdy=1 the cycle after rst deasserts.

Structure
REQ-015 SHALL place the error-class encoding (NONE/SBIT/DBIT/FAULT) and FSM state encoding in the shared ECC package.
REQ-016 SHALL use one sub-module, ecc_sat_cnt (parameterised saturating counter with sync clear and increment), instanced three times.

Verification
REQ-017 Clean stream: 10 back-to-back words, out_rdy=1, no errors -> 10 outputs with 1-cycle latency, out_err=0, counters 0, err_irq=0.
REQ-018 Backpressure: out_rdy=0 for 3 cycles after word A -> in_rdy=0, out_data=A stable, word B accepted on first out_rdy=1 cycle.
REQ-019 Capture: sbit at addr 0x12 then dbit at addr 0x34 -> first_addr=0x12, first_type=1, sbit_cnt=1, dbit_cnt=1, err_irq=1 after the dbit word.
REQ-020 Threshold/saturation: 16 sbit words -> err_irq rises the cycle after the 16th; with CNT_WIDTH=4, 20 sbit words -> sbit_cnt=15.
REQ-021 Coincident clr: clr and fault word at addr 0x07 in the same cycle, after prior errors -> fault_cnt=1, other counters 0, first_addr=0x07, first_type=3, err_irq=1.
REQ-022 Reset mid-operation: rst while out_vld=1 and out_rdy=0 -> next cycle out_vld=0, counters 0, in_rdy=1 after release.
